// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the MSB-first serial-in, parallel-out receiver.
package sipo_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Enough bits to hold counts 0..width-1 (width is always at least 2).
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output and status signals of the deserializer, grouped with directional modports.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);

  logic             sin;
  logic             sin_valid;
  logic             clear;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output sin, sin_valid, clear, dout_ready,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  sin, sin_valid, clear, dout_ready,
    output dout, dout_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_deserializer_word_buffer.sv
// Output holding register: keeps one finished word behind a valid/ready handshake and flags dropped words.
module sipo_deserializer_word_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word,
  input  logic             load,
  input  logic             dout_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             take;

  // A held word leaving on this edge frees the slot for a word completing on the same edge.
  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    take      = valid_q && dout_ready;

    if (take) begin
      valid_d = 1'b0;
    end

    if (load) begin
      if (!valid_q || take) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-in, parallel-out receiver: shift chain, bit counter and IDLE/SHIFT FSM feeding a word buffer.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  sipo_deserializer_if.slave bus
);

  localparam int             CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             word_load;
  logic [WIDTH-1:0] word_next;

  // clear wins over an incoming bit; the WIDTH-th bit hands the word to the buffer and rewinds to IDLE.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    word_load = 1'b0;
    word_next = {shift_q[WIDTH-2:0], bus.sin};

    if (bus.clear) begin
      state_d = IDLE;
      shift_d = '0;
      count_d = '0;
    end else if (bus.sin_valid) begin
      shift_d = word_next;
      unique case (state_q)
        IDLE: begin
          count_d = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (count_q == LAST) begin
            word_load = 1'b1;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: begin
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;

  sipo_deserializer_word_buffer #(
    .WIDTH(WIDTH)
  ) u_word_buffer (
    .clk       (clk),
    .reset     (reset),
    .word      (word_next),
    .load      (word_load),
    .dout_ready(bus.dout_ready),
    .clear     (bus.clear),
    .dout      (bus.dout),
    .dout_valid(bus.dout_valid),
    .overrun   (bus.overrun)
  );

endmodule
